// File: rtl/exe_muldiv_unit.sv
// Iterative RV32M multiply/divide unit sitting behind the ID/EX register.
// A start in IDLE captures op, rd and operand magnitudes. 32 CALC iterations
// follow (shift-add multiply or restoring divide). One FIN cycle applies the
// sign fix-up and the special cases, then registers the result with a
// one-cycle done pulse. Latency is a fixed 34 cycles from start to done.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start_i              EXE holds an M-extension instruction
//   op_i                 funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   rs1_i, rs2_i         operands A and B
//   rd_i                 destination register of the instruction
//   flush_i              synchronous abort of the in-flight operation
//   busy_o               operation in progress
//   stall_o              hold PC, IF/ID and ID/EX (combinational)
//   done_o               one-cycle pulse, result_o/rd_o valid
//   result_o, rd_o       registered result and destination
module exe_muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  localparam int unsigned CntW = $clog2(XLEN);

  localparam logic [2:0] OpMul    = 3'b000;
  localparam logic [2:0] OpMulh   = 3'b001;
  localparam logic [2:0] OpMulhsu = 3'b010;
  localparam logic [2:0] OpMulhu  = 3'b011;
  localparam logic [2:0] OpDiv    = 3'b100;
  localparam logic [2:0] OpDivu   = 3'b101;
  localparam logic [2:0] OpRem    = 3'b110;
  localparam logic [2:0] OpRemu   = 3'b111;

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [4:0]          rd_q, rd_d;
  logic [4:0]          rd_out_q, rd_out_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                done_q, done_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  // a_q: multiplicand, or dividend shifting out / quotient shifting in.
  // b_q: multiplier shifting right, or divisor.
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [XLEN-1:0]     rs1_q, rs1_d;
  logic                neg_q, neg_d;       // negate product / quotient
  logic                neg_rem_q, neg_rem_d;
  logic                dz_q, dz_d;
  logic                ovf_q, ovf_d;

  // Operand sign handling at capture time
  logic            sgn_a, sgn_b;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    sgn_a = rs1_i[XLEN-1] & (op_i == OpMulh || op_i == OpMulhsu ||
                             op_i == OpDiv  || op_i == OpRem);
    sgn_b = rs2_i[XLEN-1] & (op_i == OpMulh || op_i == OpDiv || op_i == OpRem);
    mag_a = sgn_a ? (~rs1_i + 1'b1) : rs1_i;
    mag_b = sgn_b ? (~rs2_i + 1'b1) : rs2_i;
  end

  // One iteration of each algorithm
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     div_diff;
  logic              div_ge;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (b_q[0] ? {1'b0, a_q} : '0);
    rem_sh   = {rem_q, a_q[XLEN-1]};
    // rem_q < divisor, so a set top bit of the difference means "does not fit"
    div_diff = rem_sh - {1'b0, b_q};
    div_ge   = ~div_diff[XLEN];
  end

  // Sign fix-up and result select for FIN
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   remd;
  logic [XLEN-1:0]   fin_res;

  always_comb begin
    prod = neg_q ? (~acc_q + 1'b1) : acc_q;
    quot = neg_q ? (~a_q + 1'b1) : a_q;
    remd = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
    unique case (op_q)
      OpMul:                     fin_res = prod[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: fin_res = prod[2*XLEN-1:XLEN];
      OpDiv:                     fin_res = dz_q ? '1 : (ovf_q ? MinNeg : quot);
      OpDivu:                    fin_res = dz_q ? '1 : a_q;
      OpRem:                     fin_res = dz_q ? rs1_q : (ovf_q ? '0 : remd);
      OpRemu:                    fin_res = dz_q ? rs1_q : rem_q;
      default:                   fin_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rd_out_d  = rd_out_q;
    result_d  = result_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    rs1_d     = rs1_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      StIdle: begin
        // done_q guard: the finished instruction still sits in ID/EX
        if (start_i && !done_q && !flush_i) begin
          op_d      = op_i;
          rd_d      = rd_i;
          rs1_d     = rs1_i;
          a_d       = mag_a;
          b_d       = mag_b;
          neg_d     = sgn_a ^ sgn_b;
          neg_rem_d = sgn_a;
          dz_d      = (rs2_i == '0);
          ovf_d     = (rs1_i == MinNeg) && (rs2_i == '1);
          acc_d     = '0;
          rem_d     = '0;
          cnt_d     = CntW'(XLEN - 1);
          state_d   = StCalc;
        end
      end
      StCalc: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          if (op_q[2]) begin
            rem_d = div_ge ? div_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
            a_d   = {a_q[XLEN-2:0], div_ge};
          end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
            b_d   = {1'b0, b_q[XLEN-1:1]};
          end
          if (cnt_q == '0) begin
            state_d = StFin;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
        if (!flush_i) begin
          result_d = fin_res;
          rd_out_d = rd_q;
          done_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= '0;
      rd_q      <= '0;
      rd_out_q  <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      rs1_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      rd_out_q  <= rd_out_d;
      result_q  <= result_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      rs1_q     <= rs1_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy_o   = (state_q != StIdle);
  assign stall_o  = busy_o | (start_i & ~done_q & (state_q == StIdle));
  assign done_o   = done_q;
  assign result_o = result_q;
  assign rd_o     = rd_out_q;

endmodule
